ddr_ring_addr_ctrl: RTL and testbench

Ring-buffer address controller for the DDR2 sample store. It generates the write and read burst addresses for the DDR burst engine and advances them on the engine's per-burst address-increment pulses. It tracks the buffer fill level and gates the read side, so the DDR region behaves as a large circular FIFO between the ADC-side FIFO and the processing-side FIFO. It sits beside the DDR top-level, in the phy_clk domain.

---
 rtl/ddr_ring_addr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ddr_ring_addr_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ring_addr_ctrl.sv
// Ring-buffer address controller for the DDR2 sample store.
// Generates the write and read burst addresses and tracks the fill level, so
// the DDR region acts as a circular FIFO between the ADC and processing sides.
module ddr_ring_addr_ctrl #(
    parameter int ADDR_WIDTH = 25,
    parameter int BURST_LEN  = 4,
    parameter int DEPTH_LOG2 = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  phy_clk,
    input  logic                  rst,
    input  logic                  local_init_done,
    input  logic                  wr_addr_up,
    input  logic                  rd_addr_up,
    input  logic                  burst_busy,
    input  logic                  clear_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  read_en,
    output logic                  wr_allow,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [1:0] INIT_WAIT = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] FLUSH     = 2'd2;

    // Pointer step; offsets are DEPTH_LOG2 bits wide so wrap is free.
    localparam logic [DEPTH_LOG2-1:0] PTR_STEP = DEPTH_LOG2'(BURST_LEN);
    // Level constants: one burst, and the highest level that still fits a burst.
    localparam logic [DEPTH_LOG2:0] LVL_STEP = (DEPTH_LOG2+1)'(BURST_LEN);
    localparam logic [DEPTH_LOG2:0] LVL_HI   = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - BURST_LEN);

    logic [1:0]            state, state_n;
    logic [DEPTH_LOG2-1:0] wr_off, wr_off_n;
    logic [DEPTH_LOG2-1:0] rd_off, rd_off_n;
    logic [DEPTH_LOG2:0]   level_n;
    logic                  overflow_n, underflow_n;
    logic                  pulse_en;
    logic                  has_burst, has_room;

    assign has_burst = (level >= LVL_STEP);
    assign has_room  = (level <= LVL_HI);

    // Next-state, pointer and level computation from registered state and pulses.
    always_comb begin
        state_n     = state;
        wr_off_n    = wr_off;
        rd_off_n    = rd_off;
        level_n     = level;
        overflow_n  = overflow;
        underflow_n = underflow;
        pulse_en    = 1'b0;

        case (state)
            INIT_WAIT: begin
                wr_off_n    = '0;
                rd_off_n    = '0;
                level_n     = '0;
                overflow_n  = 1'b0;
                underflow_n = 1'b0;
                if (local_init_done) state_n = RUN;
            end
            RUN: begin
                if (!local_init_done) begin
                    state_n     = INIT_WAIT;
                    wr_off_n    = '0;
                    rd_off_n    = '0;
                    level_n     = '0;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                end else begin
                    pulse_en = 1'b1;
                    if (clear_req) state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (!local_init_done) begin
                    state_n     = INIT_WAIT;
                    wr_off_n    = '0;
                    rd_off_n    = '0;
                    level_n     = '0;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                end else if (!burst_busy) begin
                    state_n     = RUN;
                    wr_off_n    = '0;
                    rd_off_n    = '0;
                    level_n     = '0;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                end else begin
                    pulse_en = 1'b1;
                end
            end
            default: begin
                state_n     = INIT_WAIT;
                wr_off_n    = '0;
                rd_off_n    = '0;
                level_n     = '0;
                overflow_n  = 1'b0;
                underflow_n = 1'b0;
            end
        endcase

        // Level is always a multiple of BURST_LEN, so "no full burst" means empty.
        if (pulse_en) begin
            if (wr_addr_up && rd_addr_up) begin
                wr_off_n = wr_off + PTR_STEP;
                if (has_burst) begin
                    rd_off_n = rd_off + PTR_STEP;
                end else begin
                    level_n     = level + LVL_STEP;
                    underflow_n = 1'b1;
                end
            end else if (wr_addr_up) begin
                wr_off_n = wr_off + PTR_STEP;
                if (has_room) begin
                    level_n = level + LVL_STEP;
                end else begin
                    // Full: drop the oldest burst by dragging the read pointer along.
                    rd_off_n   = rd_off + PTR_STEP;
                    overflow_n = 1'b1;
                end
            end else if (rd_addr_up) begin
                if (has_burst) begin
                    rd_off_n = rd_off + PTR_STEP;
                    level_n  = level - LVL_STEP;
                end else begin
                    underflow_n = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge phy_clk) begin
        if (rst) begin
            state     <= INIT_WAIT;
            wr_off    <= '0;
            rd_off    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            wr_off    <= wr_off_n;
            rd_off    <= rd_off_n;
            level     <= level_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end

    assign wr_addr  = BASE_ADDR + ADDR_WIDTH'(wr_off);
    assign rd_addr  = BASE_ADDR + ADDR_WIDTH'(rd_off);
    assign read_en  = (state != INIT_WAIT) && has_burst;
    assign wr_allow = (state == RUN) && has_room;

endmodule

// File: tb/tb_ddr_ring_addr_ctrl.sv
// Directed testbench for ddr_ring_addr_ctrl (BURST_LEN=4, DEPTH=16, BASE=0x100).
module tb_ddr_ring_addr_ctrl;

    localparam int AW = 25;
    localparam int DL = 4;

    logic          phy_clk = 1'b0;
    logic          rst = 1'b1;
    logic          local_init_done = 1'b0;
    logic          wr_addr_up = 1'b0;
    logic          rd_addr_up = 1'b0;
    logic          burst_busy = 1'b0;
    logic          clear_req = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          read_en;
    logic          wr_allow;
    logic [DL:0]   level;
    logic          overflow;
    logic          underflow;

    int tests = 0;
    int failed = 0;

    ddr_ring_addr_ctrl #(
        .ADDR_WIDTH (AW),
        .BURST_LEN  (4),
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (25'h100)
    ) dut (
        .phy_clk         (phy_clk),
        .rst             (rst),
        .local_init_done (local_init_done),
        .wr_addr_up      (wr_addr_up),
        .rd_addr_up      (rd_addr_up),
        .burst_busy      (burst_busy),
        .clear_req       (clear_req),
        .wr_addr         (wr_addr),
        .rd_addr         (rd_addr),
        .read_en         (read_en),
        .wr_allow        (wr_allow),
        .level           (level),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 phy_clk = ~phy_clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic pulse(input logic w, input logic r);
        wr_addr_up = w;
        rd_addr_up = r;
        tick();
        wr_addr_up = 1'b0;
        rd_addr_up = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_wr_addr", wr_addr, 32'h100);
        check("rst_rd_addr", rd_addr, 32'h100);
        check("rst_level", level, 0);
        check("rst_read_en", read_en, 0);
        check("rst_wr_allow", wr_allow, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        // Init gating: pulses ignored before calibration
        pulse(1, 0);
        pulse(1, 0);
        check("init_wr_addr", wr_addr, 32'h100);
        check("init_level", level, 0);
        check("init_wr_allow", wr_allow, 0);
        local_init_done = 1'b1;
        tick();
        check("run_wr_allow", wr_allow, 1);
        check("run_read_en", read_en, 0);

        // Fill and wrap
        pulse(1, 0);
        check("fill1_level", level, 4);
        check("fill1_read_en", read_en, 1);
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 0);
        check("full_level", level, 16);
        check("full_wr_addr", wr_addr, 32'h100);
        check("full_wr_allow", wr_allow, 0);
        check("full_read_en", read_en, 1);
        check("full_rd_addr", rd_addr, 32'h100);

        // Overflow: oldest burst dropped
        pulse(1, 0);
        check("ovf_level", level, 16);
        check("ovf_wr_addr", wr_addr, 32'h104);
        check("ovf_rd_addr", rd_addr, 32'h104);
        check("ovf_flag", overflow, 1);
        repeat (10) tick();
        check("ovf_sticky", overflow, 1);

        // Read one burst
        pulse(0, 1);
        check("rd_rd_addr", rd_addr, 32'h108);
        check("rd_level", level, 12);
        check("rd_wr_allow", wr_allow, 1);

        // Drain to empty (rd_off 8 -> 12 -> 0 -> 4)
        pulse(0, 1);
        pulse(0, 1);
        pulse(0, 1);
        check("empty_level", level, 0);
        check("empty_rd_addr", rd_addr, 32'h104);
        check("empty_read_en", read_en, 0);
        check("empty_underflow", underflow, 0);

        // Underflow at level 0
        pulse(0, 1);
        check("unf_level", level, 0);
        check("unf_flag", underflow, 1);
        check("unf_rd_addr", rd_addr, 32'h104);

        // Simultaneous at level 0: write applied, read ignored
        pulse(1, 1);
        check("sim0_level", level, 4);
        check("sim0_wr_addr", wr_addr, 32'h108);
        check("sim0_rd_addr", rd_addr, 32'h104);

        // Simultaneous at level 8: both advance, wr wraps to base
        pulse(1, 0);
        check("pre_sim8_level", level, 8);
        pulse(1, 1);
        check("sim8_level", level, 8);
        check("sim8_wr_addr", wr_addr, 32'h100);
        check("sim8_rd_addr", rd_addr, 32'h108);
        check("sim8_unf_sticky", underflow, 1);

        // Flush held by burst_busy
        burst_busy = 1'b1;
        clear_req  = 1'b1;
        tick();
        clear_req  = 1'b0;
        check("flush_wr_allow", wr_allow, 0);
        check("flush_read_en", read_en, 1);
        check("flush_level", level, 8);
        pulse(1, 0);
        check("flush_wr_level", level, 12);
        check("flush_wr_addr", wr_addr, 32'h104);
        tick();
        check("flush_hold_level", level, 12);
        burst_busy = 1'b0;
        tick();
        check("flushdone_level", level, 0);
        check("flushdone_wr_addr", wr_addr, 32'h100);
        check("flushdone_rd_addr", rd_addr, 32'h100);
        check("flushdone_overflow", overflow, 0);
        check("flushdone_underflow", underflow, 0);
        check("flushdone_wr_allow", wr_allow, 1);

        // One-cycle flush with burst_busy low
        pulse(1, 0);
        pulse(1, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("qflush_wr_allow", wr_allow, 0);
        check("qflush_level", level, 8);
        tick();
        check("qflush_done_level", level, 0);
        check("qflush_done_wr_addr", wr_addr, 32'h100);
        check("qflush_done_wr_allow", wr_allow, 1);

        // Init loss
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 0);
        check("pre_loss_level", level, 12);
        check("pre_loss_wr_addr", wr_addr, 32'h10C);
        local_init_done = 1'b0;
        tick();
        check("loss_level", level, 0);
        check("loss_read_en", read_en, 0);
        check("loss_wr_addr", wr_addr, 32'h100);
        check("loss_rd_addr", rd_addr, 32'h100);
        check("loss_wr_allow", wr_allow, 0);
        local_init_done = 1'b1;
        tick();
        check("reinit_wr_allow", wr_allow, 1);

        // Reset mid-flush
        pulse(1, 0);
        pulse(1, 0);
        burst_busy = 1'b1;
        clear_req  = 1'b1;
        tick();
        clear_req  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        burst_busy = 1'b0;
        check("rstflush_level", level, 0);
        check("rstflush_wr_addr", wr_addr, 32'h100);
        check("rstflush_wr_allow", wr_allow, 0);
        tick();
        check("rstflush_run_wr_allow", wr_allow, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
